// File: rtl/lpc_pkg.sv
// Shared widths, FSM state encoding and the output saturation helper for the
// LPC synthesis filter.
package lpc_pkg;

    localparam int unsigned MAX_ORDER = 12;
    localparam int unsigned COEFF_W   = 12;
    localparam int unsigned SAMPLE_W  = 16;
    localparam int unsigned RES_W     = 20;
    localparam int unsigned ACC_W     = 36;
    localparam int unsigned ORDER_W   = 4;
    localparam int unsigned SHIFT_W   = 5;
    localparam int unsigned PROD_W    = COEFF_W + SAMPLE_W;
    localparam int unsigned SUM_W     = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] SAMPLE_MAX = SUM_W'((64'd1 << (SAMPLE_W - 1)) - 64'd1);
    localparam logic signed [SUM_W-1:0] SAMPLE_MIN = ~SAMPLE_MAX;

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        WAIT,
        MAC,
        OUT
    } lpc_state_e;

    // Clamp a full-width reconstruction sum into the signed output sample range.
    function automatic logic [SAMPLE_W-1:0] sat_sample(input logic signed [SUM_W-1:0] x);
        logic [SAMPLE_W-1:0] r;
        if (x > SAMPLE_MAX) begin
            r = SAMPLE_MAX[SAMPLE_W-1:0];
        end else if (x < SAMPLE_MIN) begin
            r = SAMPLE_MIN[SAMPLE_W-1:0];
        end else begin
            r = x[SAMPLE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/lpc_mac.sv
// Serial signed multiply-accumulate: one coefficient*sample product per
// enabled cycle, with a synchronous clear that takes priority.
module lpc_mac
    import lpc_pkg::*;
(
    input  logic                       iClock,
    input  logic                       iReset,
    input  logic                       iClear,
    input  logic                       iAccEn,
    input  logic signed [COEFF_W-1:0]  iCoeff,
    input  logic signed [SAMPLE_W-1:0] iSample,
    output logic signed [ACC_W-1:0]    oAcc
);

    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;

    assign prod_c = iCoeff * iSample;

    always_comb begin
        acc_d = acc_q;
        if (iClear) begin
            acc_d = '0;
        end else if (iAccEn) begin
            acc_d = acc_q + ACC_W'(prod_c);
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign oAcc = acc_q;

endmodule

// File: rtl/lpc_synthesis_filter.sv
// FLAC LPC subframe reconstruction: warm-up pass-through, then residual plus
// serially accumulated prediction. Define LPC_SAT_EN to saturate instead of wrap.
module lpc_synthesis_filter
    import lpc_pkg::*;
(
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iEnable,
    input  logic                iLoad,
    input  logic [3:0]          iM,
    input  logic [COEFF_W-1:0]  iCoeff,
    input  logic                iStart,
    input  logic [3:0]          iOrder,
    input  logic [4:0]          iShift,
    input  logic                iValid,
    input  logic [RES_W-1:0]    iResidual,
    output logic                oReady,
    output logic                oValid,
    output logic [SAMPLE_W-1:0] oSample
);

    lpc_state_e                 state_q, state_d;
    logic [ORDER_W-1:0]         order_q, order_d;
    logic [SHIFT_W-1:0]         shift_q, shift_d;
    logic [ORDER_W-1:0]         cnt_q, cnt_d;
    logic signed [RES_W-1:0]    res_q, res_d;
    logic                       valid_q, valid_d;
    logic [SAMPLE_W-1:0]        sample_q, sample_d;
    logic signed [SAMPLE_W-1:0] hist_q [MAX_ORDER];
    logic signed [SAMPLE_W-1:0] hist_d [MAX_ORDER];
    logic signed [COEFF_W-1:0]  coeff_q [MAX_ORDER];
    logic signed [COEFF_W-1:0]  coeff_d [MAX_ORDER];

    logic                       mac_clr_c;
    logic                       mac_en_c;
    logic                       push_c;
    logic [SAMPLE_W-1:0]        push_val_c;
    logic [ORDER_W-1:0]         ord_c;
    logic signed [ACC_W-1:0]    acc_c;
    logic [SAMPLE_W-1:0]        out_sample_c;

    assign ord_c  = (iOrder > ORDER_W'(MAX_ORDER)) ? ORDER_W'(MAX_ORDER) : iOrder;
    assign oReady = iEnable && ((state_q == WARMUP) || (state_q == WAIT));

    lpc_mac u_mac (
        .iClock  (iClock),
        .iReset  (iReset),
        .iClear  (mac_clr_c),
        .iAccEn  (mac_en_c),
        .iCoeff  (coeff_q[cnt_q]),
        .iSample (hist_q[cnt_q]),
        .oAcc    (acc_c)
    );

`ifdef LPC_SAT_EN
    logic signed [SUM_W-1:0] sum_c;
    assign sum_c        = SUM_W'(res_q) + SUM_W'(acc_c >>> shift_q);
    assign out_sample_c = sat_sample(sum_c);
`else
    // Low SAMPLE_W bits of the sum are exact under wrap, so add at output width.
    assign out_sample_c = SAMPLE_W'(res_q) + SAMPLE_W'(acc_c >>> shift_q);
`endif

    always_comb begin
        state_d    = state_q;
        order_d    = order_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        valid_d    = 1'b0;
        sample_d   = sample_q;
        hist_d     = hist_q;
        coeff_d    = coeff_q;
        mac_clr_c  = 1'b0;
        mac_en_c   = 1'b0;
        push_c     = 1'b0;
        push_val_c = '0;

        if (iEnable) begin
            case (state_q)
                IDLE: begin
                end
                WARMUP: begin
                    if (iValid) begin
                        push_c     = 1'b1;
                        push_val_c = SAMPLE_W'(iResidual);
                        sample_d   = SAMPLE_W'(iResidual);
                        valid_d    = 1'b1;
                        cnt_d      = cnt_q + ORDER_W'(1);
                        if (cnt_q == order_q - ORDER_W'(1)) begin
                            state_d = WAIT;
                            cnt_d   = '0;
                        end
                    end
                end
                WAIT: begin
                    if (iValid) begin
                        res_d     = iResidual;
                        mac_clr_c = 1'b1;
                        cnt_d     = '0;
                        state_d   = (order_q == '0) ? OUT : MAC;
                    end
                end
                MAC: begin
                    mac_en_c = 1'b1;
                    cnt_d    = cnt_q + ORDER_W'(1);
                    if (cnt_q == order_q - ORDER_W'(1)) begin
                        state_d = OUT;
                        cnt_d   = '0;
                    end
                end
                OUT: begin
                    sample_d   = out_sample_c;
                    valid_d    = 1'b1;
                    push_c     = 1'b1;
                    push_val_c = out_sample_c;
                    state_d    = WAIT;
                end
                default: state_d = IDLE;
            endcase

            // History shift: hist[0] is always the most recent sample.
            if (push_c) begin
                for (int unsigned i = 1; i < MAX_ORDER; i++) begin
                    hist_d[i] = hist_q[i-1];
                end
                hist_d[0] = push_val_c;
            end

            if (iLoad && (state_q != MAC) && (state_q != OUT) && (iM < ORDER_W'(MAX_ORDER))) begin
                coeff_d[iM] = iCoeff;
            end

            // Start overrides any transfer or in-flight sample in the same cycle.
            if (iStart) begin
                state_d   = (ord_c == '0) ? WAIT : WARMUP;
                order_d   = ord_c;
                shift_d   = iShift;
                cnt_d     = '0;
                res_d     = res_q;
                valid_d   = 1'b0;
                sample_d  = sample_q;
                hist_d    = '{default: '0};
                mac_clr_c = 1'b0;
                mac_en_c  = 1'b0;
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q  <= IDLE;
            order_q  <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            valid_q  <= 1'b0;
            sample_q <= '0;
            hist_q   <= '{default: '0};
            coeff_q  <= '{default: '0};
        end else begin
            state_q  <= state_d;
            order_q  <= order_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            valid_q  <= valid_d;
            sample_q <= sample_d;
            hist_q   <= hist_d;
            coeff_q  <= coeff_d;
        end
    end

    assign oValid  = valid_q;
    assign oSample = sample_q;

endmodule

// File: tb/tb_lpc_synthesis_filter.sv
// Directed, cycle-exact bench for lpc_synthesis_filter: a table of per-cycle
// inputs and expected outputs, plus hand-built abort and reset sequences.
module tb_lpc_synthesis_filter;
    import lpc_pkg::*;

`ifdef LPC_SAT_EN
    localparam int SAT_EXP = 32767;
`else
    localparam int SAT_EXP = -32768;
`endif

    typedef struct {
        string tag;
        bit    en;
        bit    start;
        int    order;
        int    shift;
        bit    load;
        int    m;
        int    coeff;
        bit    valid;
        int    res;
        bit    exp_ready;
        bit    exp_valid;
        int    exp_sample;
    } vec_t;

    logic                iClock;
    logic                iReset;
    logic                iEnable;
    logic                iLoad;
    logic [3:0]          iM;
    logic [COEFF_W-1:0]  iCoeff;
    logic                iStart;
    logic [3:0]          iOrder;
    logic [4:0]          iShift;
    logic                iValid;
    logic [RES_W-1:0]    iResidual;
    logic                oReady;
    logic                oValid;
    logic [SAMPLE_W-1:0] oSample;

    int n_checks;
    int n_fail;
    vec_t tbl[$];

    lpc_synthesis_filter dut (
        .iClock    (iClock),
        .iReset    (iReset),
        .iEnable   (iEnable),
        .iLoad     (iLoad),
        .iM        (iM),
        .iCoeff    (iCoeff),
        .iStart    (iStart),
        .iOrder    (iOrder),
        .iShift    (iShift),
        .iValid    (iValid),
        .iResidual (iResidual),
        .oReady    (oReady),
        .oValid    (oValid),
        .oSample   (oSample)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input string tag, input bit en, input bit start,
                                input int order, input int shift, input bit load,
                                input int m, input int coeff, input bit valid, input int res,
                                input bit er, input bit ev, input int es);
        vec_t v;
        v.tag = tag; v.en = en; v.start = start; v.order = order; v.shift = shift;
        v.load = load; v.m = m; v.coeff = coeff; v.valid = valid; v.res = res;
        v.exp_ready = er; v.exp_valid = ev; v.exp_sample = es;
        return v;
    endfunction

    function automatic vec_t xf(input string tag, input int res, input bit er, input bit ev, input int es);
        return mk(tag, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, res, er, ev, es);
    endfunction

    function automatic vec_t nop(input string tag, input bit er, input bit ev, input int es);
        return mk(tag, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 0, er, ev, es);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check oReady before the edge and the registered
    // outputs just after it.
    task automatic run_vec(input vec_t v);
        @(negedge iClock);
        iEnable   = v.en;
        iStart    = v.start;
        iOrder    = 4'(v.order);
        iShift    = 5'(v.shift);
        iLoad     = v.load;
        iM        = 4'(v.m);
        iCoeff    = COEFF_W'(v.coeff);
        iValid    = v.valid;
        iResidual = RES_W'(v.res);
        #1;
        chk({v.tag, ".ready"}, int'(oReady), int'(v.exp_ready));
        @(posedge iClock);
        #1;
        chk({v.tag, ".valid"}, int'(oValid), int'(v.exp_valid));
        chk({v.tag, ".sample"}, int'($signed(oSample)), v.exp_sample);
    endtask

    initial begin
        int prev;
        n_checks  = 0;
        n_fail    = 0;
        iReset    = 1'b0;
        iEnable   = 1'b0;
        iStart    = 1'b0;
        iOrder    = '0;
        iShift    = '0;
        iLoad     = 1'b0;
        iM        = '0;
        iCoeff    = '0;
        iValid    = 1'b0;
        iResidual = '0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge iClock);
            iEnable   = 1'($urandom);
            iStart    = 1'($urandom);
            iOrder    = 4'($urandom);
            iShift    = 5'($urandom);
            iLoad     = 1'($urandom);
            iM        = 4'($urandom);
            iCoeff    = COEFF_W'($urandom);
            iValid    = 1'($urandom);
            iResidual = RES_W'($urandom);
            #1;
            chk("rst.ready", int'(oReady), 0);
            chk("rst.valid", int'(oValid), 0);
            chk("rst.sample", int'($signed(oSample)), 0);
        end
        @(negedge iClock);
        iStart = 1'b0;
        iLoad  = 1'b0;
        iReset = 1'b1;

        // After release: IDLE ignores valid input until a start
        for (int i = 0; i < 3; i++) tbl.push_back(xf("idle", 123, 0, 0, 0));

        // Order 1, coeff 1, shift 0
        tbl.push_back(mk("t1.start", 1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(xf("t1.wu", 100, 1, 1, 100));
        tbl.push_back(xf("t1.r0", 5, 1, 0, 100));
        tbl.push_back(nop("t1.mac0", 0, 0, 100));
        tbl.push_back(nop("t1.out0", 0, 1, 105));
        tbl.push_back(xf("t1.r1", 5, 1, 0, 105));
        tbl.push_back(nop("t1.mac1", 0, 0, 105));
        tbl.push_back(nop("t1.out1", 0, 1, 110));
        tbl.push_back(xf("t1.r2", -3, 1, 0, 110));
        tbl.push_back(nop("t1.mac2", 0, 0, 110));
        tbl.push_back(nop("t1.out2", 0, 1, 107));

        // Order 2, coeffs 2 and -1 (second load overlaps the first warm-up transfer)
        tbl.push_back(mk("t2.start", 1, 1, 2, 0, 1, 0, 2, 0, 0, 1, 0, 107));
        tbl.push_back(mk("t2.wu0", 1, 0, 0, 0, 1, 1, -1, 1, 0, 1, 1, 0));
        tbl.push_back(xf("t2.wu1", 10, 1, 1, 10));
        prev = 10;
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(xf("t2.r", 0, 1, 0, prev));
            tbl.push_back(nop("t2.mac", 0, 0, prev));
            tbl.push_back(nop("t2.mac", 0, 0, prev));
            tbl.push_back(nop("t2.out", 0, 1, 20 + 10 * k));
            prev = 20 + 10 * k;
        end

        // Order 1, coeff 3, shift 1; includes an iEnable-low freeze in WAIT
        tbl.push_back(mk("t3.start", 1, 1, 1, 1, 1, 0, 3, 0, 0, 1, 0, 40));
        tbl.push_back(xf("t3.wu", 7, 1, 1, 7));
        tbl.push_back(mk("t3.frz", 0, 0, 0, 0, 0, 0, 0, 1, 99, 0, 0, 7));
        tbl.push_back(xf("t3.r", 0, 1, 0, 7));
        tbl.push_back(nop("t3.mac", 0, 0, 7));
        tbl.push_back(nop("t3.out", 0, 1, 10));
        tbl.push_back(mk("t3.restart", 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 10));
        tbl.push_back(xf("t3.wun", -7, 1, 1, -7));
        tbl.push_back(xf("t3.rn", 0, 1, 0, -7));
        tbl.push_back(nop("t3.macn", 0, 0, -7));
        tbl.push_back(nop("t3.outn", 0, 1, -11));

        // Overflow at the positive sample limit
        tbl.push_back(mk("t4.start", 1, 1, 1, 0, 1, 0, 1, 0, 0, 1, 0, -11));
        tbl.push_back(xf("t4.wu", 32767, 1, 1, 32767));
        tbl.push_back(xf("t4.r", 1, 1, 0, 32767));
        tbl.push_back(nop("t4.mac", 0, 0, 32767));
        tbl.push_back(nop("t4.out", 0, 1, SAT_EXP));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // Order 12, all coeffs 1: abort mid-MAC and restart
        for (int i = 0; i < 12; i++) run_vec(mk("t5.load", 1, 0, 0, 0, 1, i, 1, 0, 0, 1, 0, SAT_EXP));
        run_vec(mk("t5.start", 1, 1, 12, 0, 0, 0, 0, 0, 0, 1, 0, SAT_EXP));
        for (int k = 1; k <= 12; k++) run_vec(xf("t5.wu", k, 1, 1, k));
        run_vec(xf("t5.r", 0, 1, 0, 12));
        for (int i = 0; i < 5; i++) run_vec(nop("t5.mac", 0, 0, 12));
        run_vec(mk("t5.abort", 1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 12));
        run_vec(nop("t5.after", 1, 0, 12));
        for (int k = 0; k < 12; k++) run_vec(xf("t5.wu2", 2, 1, 1, 2));
        run_vec(xf("t5.r2", 5, 1, 0, 2));
        run_vec(mk("t5.ldmac", 1, 0, 0, 0, 1, 0, 100, 0, 0, 0, 0, 2));
        for (int i = 0; i < 11; i++) run_vec(nop("t5.mac2", 0, 0, 2));
        run_vec(nop("t5.out2", 0, 1, 29));
        // Next sample proves the MAC-time load of coeff[0] was ignored
        run_vec(xf("t5.r3", 0, 1, 0, 29));
        for (int i = 0; i < 12; i++) run_vec(nop("t5.mac3", 0, 0, 29));
        run_vec(nop("t5.out3", 0, 1, 51));

        // Asynchronous reset mid-cycle
        run_vec(xf("t6.r", 0, 1, 0, 51));
        @(negedge iClock);
        iValid = 1'b0;
        #2;
        iReset = 1'b0;
        #1;
        chk("t6.rst.ready", int'(oReady), 0);
        chk("t6.rst.valid", int'(oValid), 0);
        chk("t6.rst.sample", int'($signed(oSample)), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lpc_synthesis_filter.md
# lpc_synthesis_filter

Decoder-side counterpart of the encoder's FIR predictor bank. The block reconstructs PCM samples from a FLAC LPC subframe: warm-up samples pass straight through, then each residual is added to a quantised linear prediction formed from previously reconstructed samples. It sits after the residual (Rice) decoder and before the output sample sink. It uses a single serial multiply-accumulate unit, iterating over the taps.

## Interface
- MAX_ORDER, 12, number of coefficient slots; orders 0..MAX_ORDER are supported
- COEFF_W, 12, signed quantised coefficient width
- SAMPLE_W, 16, signed output sample width
- RES_W, 20, signed residual width
- ACC_W, 36, signed accumulator width
- iClock  in  1  single clock, rising edge
- iReset  in  1  asynchronous, active-low reset
- iEnable  in  1  global clock-enable; when low, all state freezes and oReady is low
- iLoad  in  1  coefficient write strobe
- iM  in  4  coefficient index j (0..MAX_ORDER-1); tap j multiplies the sample from j+1 steps back
- iCoeff  in  COEFF_W  signed coefficient
- iStart  in  1  start-of-subframe pulse; latches iOrder and iShift
- iOrder  in  4  predictor order N; values above MAX_ORDER are clamped
- iShift  in  5  quantisation shift, 0..31
- iValid  in  1  iResidual valid
- iResidual  in  RES_W  signed input; carries a verbatim sample during warm-up and a residual afterwards
- oReady  out  1  block accepts iResidual this cycle
- oValid  out  1  one-cycle pulse; oSample holds a new sample
- oSample  out  SAMPLE_W  reconstructed signed sample

## Operation
- Reset values: state IDLE, oReady 0, oValid 0, oSample 0, history cleared to 0, coefficients cleared to 0, N and shift cleared to 0.
- A transfer occurs on any edge where iValid && oReady && iEnable.
- **IDLE:** oReady is 0. iStart moves to WARMUP, or to WAIT if N=0.
- **WARMUP:** oReady is 1. Each transfer does three things:
  - registers iResidual[SAMPLE_W-1:0] to oSample;
  - pulses oValid;
  - pushes the sample into the history.
  - After N transfers, move to WAIT.
- **WAIT:** oReady is 1. A transfer latches the residual and clears the accumulator. Go to MAC, or to OUT if N=0.
- **MAC:** lasts N cycles. Each cycle does acc += coeff[j]*hist[j] for j=0..N-1, with hist[0] the most recent sample. oReady is 0.
- **OUT:** lasts 1 cycle.
  - Compute sample = residual + (acc >>> shift), using an arithmetic shift.
  - Truncate the result to SAMPLE_W bits (two's-complement wrap).
  - Register oSample, pulse oValid, push the sample into the history, return to WAIT.
- iLoad writes coeff[iM] in any state except MAC and OUT; it is ignored in those states. iM ≥ MAX_ORDER is ignored.
- iStart in any state:
  - aborts any in-progress sample, with no oValid for the aborted sample;
  - clears the history;
  - latches N and shift;
  - enters WARMUP (or WAIT if N=0).
- Priority rules:
  - iStart together with a transfer: iStart wins and the input is dropped.
  - iStart together with iLoad: both take effect.
- Asserting iReset mid-operation returns the block to reset values immediately.

## Timing
- Warm-up sample: oValid is high in the cycle after the transfer edge (latency 1).
- Predicted sample: latency N+1 edges from the transfer edge (N MAC + 1 OUT). For N=0, latency is 1.
- Sustained throughput: one predicted sample per N+2 cycles, since WAIT takes at least 1 cycle.
- oValid is registered and lasts exactly one cycle.
- oReady is combinational from the state and iEnable.

## Configuration
- LPC_SAT_EN defined: the OUT result saturates to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- LPC_SAT_EN undefined: the result wraps, which is bit-exact with the FLAC reference decoder.

## Structure
- Package lpc_pkg holds:
  - MAX_ORDER, COEFF_W, SAMPLE_W, RES_W, ACC_W;
  - the state enum (IDLE, WARMUP, WAIT, MAC, OUT);
  - the saturation helper function.
- Sub-module lpc_mac holds the signed multiplier and accumulator, with clear and accumulate-enable controls. The FSM, coefficient RAM and history shift register stay in the top level.

## Test plan
- Reset: hold iReset low with random inputs → oReady 0, oValid 0, oSample 0. After release, oReady stays 0 until iStart.
- Order 1, coeff[0]=1, shift 0. Inputs: warm-up 100, then residuals 5, 5, -3 → oSample 100, 105, 110, 107. Each predicted oValid arrives 2 edges after its transfer.
- Order 2, coeffs 2 and -1, shift 0. Inputs: warm-up 0 then 10, then three residuals of 0 → 20, 30, 40. Transfers are spaced 4 cycles apart.
- Order 1, coeff 3, shift 1:
  - warm-up 7, residual 0 → 10;
  - restart, warm-up -7, residual 0 → -11 (checks the arithmetic shift).
- Order 1, coeff 1, warm-up 32767, residual 1:
  - → -32768 without LPC_SAT_EN;
  - → 32767 with LPC_SAT_EN.
- Order 12, iStart pulsed mid-MAC → no oValid for the aborted sample, WARMUP entered, oReady high on the next cycle. The next predicted sample uses the cleared history.
